// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slew-limits the duty setpoint that feeds the PWM core.
// A captured target is approached in steps of max(step_size,1). A step is
// taken once every (ramp_div+1) PWM period_end pulses and never passes the
// target. duty_upd marks the first cycle in which a new duty_out is visible.
//
// Handshake: target_load and period_end are single-cycle strobes. Both are
// qualified by ena; they are ignored while ena is low. If the two strobes
// coincide, the load takes priority and the step is dropped.
module pwm_duty_ramp #(
  parameter int DUTY_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_load,
  input  logic [3:0]        step_size,
  input  logic [DIV_W-1:0]  ramp_div,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_upd,
  output logic              busy,
  output logic              at_target,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DUTY_W-1:0] target_q, target_n;
  logic [DUTY_W-1:0] duty_n;
  logic [DIV_W-1:0]  presc, presc_n;
  logic              upd_n;

  // One extra bit so the sum and difference cannot wrap at either end.
  logic [DUTY_W:0]   step_w;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_diff;
  logic [DUTY_W-1:0] stepped;

  // Candidate duty value after one step toward the target, clamped at the target.
  always_comb begin
    step_w       = '0;
    step_w[3:0]  = (step_size == 4'd0) ? 4'd1 : step_size;
    up_sum       = {1'b0, duty_out} + step_w;
    dn_diff      = {1'b0, duty_out} - step_w;
    stepped      = duty_out;
    if (state == RAMP_UP) begin
      stepped = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[DUTY_W-1:0];
    end else if (state == RAMP_DOWN) begin
      stepped = (dn_diff[DUTY_W] || (dn_diff[DUTY_W-1:0] <= target_q))
                ? target_q : dn_diff[DUTY_W-1:0];
    end
  end

  // Next-state logic: a load beats a step, and ena low freezes everything.
  always_comb begin
    state_n  = state;
    target_n = target_q;
    duty_n   = duty_out;
    presc_n  = presc;
    upd_n    = 1'b0;
    if (ena) begin
      if (target_load) begin
        target_n = target_duty;
        presc_n  = '0;
        if (target_duty > duty_out) begin
          state_n = RAMP_UP;
        end else if (target_duty < duty_out) begin
          state_n = RAMP_DOWN;
        end else begin
          state_n = IDLE;
        end
      end else if (period_end && (state != IDLE)) begin
        if (presc == ramp_div) begin
          presc_n = '0;
          duty_n  = stepped;
          upd_n   = 1'b1;
          if (stepped == target_q) begin
            state_n = IDLE;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target_q <= '0;
      duty_out <= '0;
      presc    <= '0;
      duty_upd <= 1'b0;
    end else begin
      state    <= state_n;
      target_q <= target_n;
      duty_out <= duty_n;
      presc    <= presc_n;
      duty_upd <= upd_n;
    end
  end

  // Status flags decoded from registered state only.
  assign busy      = (state == RAMP_UP) || (state == RAMP_DOWN);
  assign at_target = (duty_out == target_q);
  assign state_dbg = state;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: ramp up, clamping, divider, reversal
// with a load/period_end collision, enable freeze and mid-ramp reset.
module tb_pwm_duty_ramp;

  localparam int DUTY_W = 8;
  localparam int DIV_W  = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic [DUTY_W-1:0] target_duty;
  logic              target_load;
  logic [3:0]        step_size;
  logic [DIV_W-1:0]  ramp_div;
  logic              period_end;
  logic [DUTY_W-1:0] duty_out;
  logic              duty_upd;
  logic              busy;
  logic              at_target;
  logic [1:0]        state_dbg;

  int errors;
  int checks;
  int upd_cnt;
  int saved_cnt;

  pwm_duty_ramp #(.DUTY_W(DUTY_W), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .target_duty (target_duty),
    .target_load (target_load),
    .step_size   (step_size),
    .ramp_div    (ramp_div),
    .period_end  (period_end),
    .duty_out    (duty_out),
    .duty_upd    (duty_upd),
    .busy        (busy),
    .at_target   (at_target),
    .state_dbg   (state_dbg)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle 1ns; duty_upd pulses are tallied here.
  task automatic tick();
    @(posedge clk);
    #1;
    if (duty_upd) upd_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  task automatic load(input logic [DUTY_W-1:0] t, input logic [3:0] s,
                      input logic [DIV_W-1:0] d);
    step_size   = s;
    ramp_div    = d;
    target_duty = t;
    target_load = 1'b1;
    tick();
    target_load = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0; checks = 0; upd_cnt = 0; saved_cnt = 0;
    rst_n = 1'b0; ena = 1'b0; target_duty = '0; target_load = 1'b0;
    step_size = 4'd0; ramp_div = '0; period_end = 1'b0;

    // Reset values, observed before any clock edge
    #3;
    check("rst_duty", duty_out, 0);
    check("rst_upd", duty_upd, 0);
    check("rst_busy", busy, 0);
    check("rst_at_target", at_target, 1);
    check("rst_state", state_dbg, S_IDLE);
    idle(2);
    rst_n = 1'b1;
    ena   = 1'b1;
    idle(2);

    // Basic ramp up: 0 -> 16 in steps of 4, one step per period_end
    upd_cnt = 0;
    load(8'd16, 4'd4, 8'd0);
    check("up_state", state_dbg, S_UP);
    check("up_busy", busy, 1);
    check("up_at_target", at_target, 0);
    check("up_duty0", duty_out, 0);
    for (int i = 1; i <= 4; i++) begin
      idle(9);
      check("up_hold", duty_out, (i - 1) * 4);
      pulse_pe();
      check("up_duty", duty_out, i * 4);
      check("up_upd", duty_upd, 1);
    end
    check("up_done_busy", busy, 0);
    check("up_done_at_target", at_target, 1);
    tick();
    check("up_upd_one_cycle", duty_upd, 0);
    check("up_upd_count", upd_cnt, 4);
    // period_end in IDLE does nothing
    pulse_pe();
    check("idle_pe_duty", duty_out, 16);
    check("idle_pe_upd", duty_upd, 0);

    // Ramp to 250 with step 15 (16 + 15k clamps on the last step)
    load(8'd250, 4'd15, 8'd0);
    for (int i = 0; i < 40 && !at_target; i++) pulse_pe();
    check("to250_duty", duty_out, 250);
    // Clamp at top: 250 + 15 must give 255, not wrap to 9
    load(8'd255, 4'd15, 8'd0);
    pulse_pe();
    check("clamp_top", duty_out, 255);
    check("clamp_top_idle", state_dbg, S_IDLE);
    // Down to 5 with step 15, then 5 -> 0 with step 8 (no wrap to 253)
    load(8'd5, 4'd15, 8'd0);
    check("down_state", state_dbg, S_DOWN);
    for (int i = 0; i < 40 && !at_target; i++) pulse_pe();
    check("to5_duty", duty_out, 5);
    load(8'd0, 4'd8, 8'd0);
    pulse_pe();
    check("clamp_bottom", duty_out, 0);
    check("clamp_bottom_busy", busy, 0);

    // step_size of 0 behaves as 1
    load(8'd2, 4'd0, 8'd0);
    pulse_pe();
    check("step0_a", duty_out, 1);
    pulse_pe();
    check("step0_b", duty_out, 2);
    load(8'd0, 4'd8, 8'd0);
    pulse_pe();
    check("back_to_0", duty_out, 0);

    // Divider: ramp_div=2 means one step every third period_end
    load(8'd3, 4'd1, 8'd2);
    for (int i = 1; i <= 9; i++) begin
      idle(3);
      pulse_pe();
      check("div_duty", duty_out, i / 3);
      check("div_upd", duty_upd, (i % 3 == 0) ? 1 : 0);
    end
    check("div_idle", state_dbg, S_IDLE);
    load(8'd0, 4'd8, 8'd0);
    pulse_pe();

    // Reversal: ramping 0 -> 60 by 4, retarget 10 at 40 with a coinciding period_end
    load(8'd60, 4'd4, 8'd0);
    for (int i = 0; i < 10; i++) pulse_pe();
    check("rev_at40", duty_out, 40);
    check("rev_up", state_dbg, S_UP);
    ramp_div    = 8'd1;
    target_duty = 8'd10;
    target_load = 1'b1;
    period_end  = 1'b1;
    tick();
    target_load = 1'b0;
    period_end  = 1'b0;
    check("rev_hold", duty_out, 40);
    check("rev_no_upd", duty_upd, 0);
    check("rev_down", state_dbg, S_DOWN);
    pulse_pe();
    check("rev_first_pe", duty_out, 40);
    pulse_pe();
    check("rev_step", duty_out, 36);

    // ena low freezes: period_end and target_load are ignored
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_pe();
      check("ena0_duty", duty_out, 36);
      check("ena0_upd", duty_upd, 0);
    end
    target_duty = 8'd200;
    target_load = 1'b1;
    tick();
    target_load = 1'b0;
    check("ena0_load_ignored", state_dbg, S_DOWN);
    ena = 1'b1;
    pulse_pe();
    check("ena1_presc", duty_out, 36);
    pulse_pe();
    check("ena1_step", duty_out, 32);

    // Asynchronous reset mid-ramp abandons the ramp
    rst_n = 1'b0;
    #2;
    check("arst_duty", duty_out, 0);
    check("arst_busy", busy, 0);
    check("arst_at_target", at_target, 1);
    tick();
    rst_n = 1'b1;
    saved_cnt = upd_cnt;
    for (int i = 0; i < 3; i++) pulse_pe();
    check("post_rst_duty", duty_out, 0);
    check("post_rst_state", state_dbg, S_IDLE);
    check("post_rst_upd", upd_cnt, saved_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
